// File: rtl/sub4_serial.sv
// Bit-serial subtractor: one difference bit per clock, LSB first, result and
// borrow registered on completion. Optional signed-overflow flag via SUB4_SERIAL_OVF_EN.
module sub4_serial #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Diff,
   output logic             Borrow,
`ifdef SUB4_SERIAL_OVF_EN
   output logic             Ovf,
`endif
   output logic             busy,
   output logic             done
);

   // state | meaning
   // IDLE  | waiting for start; Diff/Borrow hold last result
   // RUN   | one bit per cycle, WIDTH cycles
   // DONE  | result just loaded; done pulses for this cycle
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [CW-1:0]    cnt;
   logic             br;
   logic             d_bit;
   logic             br_next;

   assign d_bit   = a_sh[0] ^ b_sh[0] ^ br;
   assign br_next = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         cnt    <= '0;
         br     <= 1'b0;
         Diff   <= '0;
         Borrow <= 1'b0;
`ifdef SUB4_SERIAL_OVF_EN
         Ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh  <= A;
                  b_sh  <= B;
                  cnt   <= '0;
                  br    <= 1'b0;
                  state <= RUN;
               end
            end
            RUN: begin
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               res_sh <= {d_bit, res_sh[WIDTH-1:1]};
               br     <= br_next;
               if (cnt == LAST) begin
                  cnt    <= '0;
                  Diff   <= {d_bit, res_sh[WIDTH-1:1]};
                  Borrow <= br_next;
`ifdef SUB4_SERIAL_OVF_EN
                  // on the last bit the operand LSBs are the original sign bits
                  Ovf    <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
`endif
                  state  <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub4_serial.sv
// Directed bench for sub4_serial (WIDTH=4): vector table plus hand-written
// sequences for ignored start, mid-run reset and back-to-back operation.
module tb_sub4_serial;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [W-1:0] Diff;
   logic         Borrow;
   logic         busy;
   logic         done;
`ifdef SUB4_SERIAL_OVF_EN
   logic         Ovf;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic         br;
      logic         ovf;
   } vec_t;

   vec_t vecs [9];
   logic [W-1:0] prev_d;
   logic         prev_br;

   sub4_serial #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .A      (A),
      .B      (B),
      .Diff   (Diff),
      .Borrow (Borrow),
`ifdef SUB4_SERIAL_OVF_EN
      .Ovf    (Ovf),
`endif
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drives one operation and follows it to its done pulse.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic ebr, input logic eovf);
      int lat;
      int busy_cnt;
      bit held;
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; busy_cnt = 0; held = 1'b1;
      while (done !== 1'b1 && lat < 20) begin
         if (busy === 1'b1) busy_cnt++;
         if (Diff !== prev_d || Borrow !== prev_br) held = 1'b0;
         @(negedge clk);
         lat++;
      end
      check("done_latency", lat, W);
      check("busy_cycles", busy_cnt, W);
      check("hold_during_run", int'(held), 1);
      check("diff", int'(Diff), int'(ed));
      check("borrow", int'(Borrow), int'(ebr));
`ifdef SUB4_SERIAL_OVF_EN
      check("ovf", int'(Ovf), int'(eovf));
`else
      if (eovf === 1'bx) check("ovf_unused", 0, 1);
`endif
      prev_d = ed; prev_br = ebr;
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
   endtask

   initial begin
      int n_done;
      int t0, t1;
      logic [W-1:0] r0, r1;

      vecs[0] = '{a: 4'b1000, b: 4'b0110, d: 4'b0010, br: 1'b0, ovf: 1'b1};
      vecs[1] = '{a: 4'b1011, b: 4'b1111, d: 4'b1100, br: 1'b1, ovf: 1'b0};
      vecs[2] = '{a: 4'b0011, b: 4'b0010, d: 4'b0001, br: 1'b0, ovf: 1'b0};
      vecs[3] = '{a: 4'b0000, b: 4'b0001, d: 4'b1111, br: 1'b1, ovf: 1'b0};
      vecs[4] = '{a: 4'b1000, b: 4'b0001, d: 4'b0111, br: 1'b0, ovf: 1'b1};
      vecs[5] = '{a: 4'b1111, b: 4'b1111, d: 4'b0000, br: 1'b0, ovf: 1'b0};
      vecs[6] = '{a: 4'b0111, b: 4'b1000, d: 4'b1111, br: 1'b1, ovf: 1'b1};
      vecs[7] = '{a: 4'b0101, b: 4'b0011, d: 4'b0010, br: 1'b0, ovf: 1'b0};
      vecs[8] = '{a: 4'b0001, b: 4'b1110, d: 4'b0011, br: 1'b1, ovf: 1'b0};

      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      prev_d = '0; prev_br = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_diff", int'(Diff), 0);
      check("rst_borrow", int'(Borrow), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].br, vecs[i].ovf);

      // start and new operands during RUN must be ignored
      @(negedge clk);
      A = 4'b1010; B = 4'b0110; start = 1'b1;
      @(negedge clk);
      A = 4'b0000; B = 4'b1111;
      @(negedge clk);
      start = 1'b0;
      n_done = 0;
      for (int c = 0; c < W + 8; c++) begin
         if (done === 1'b1) begin
            n_done++;
            check("ign_diff", int'(Diff), 4'b0100);
            check("ign_borrow", int'(Borrow), 0);
         end
         @(negedge clk);
      end
      check("ign_done_count", n_done, 1);
      prev_d = 4'b0100; prev_br = 1'b0;

      // reset on the second RUN cycle aborts without a done pulse
      @(negedge clk);
      A = 4'b1011; B = 4'b0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_diff", int'(Diff), 0);
      check("abort_borrow", int'(Borrow), 0);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      n_done = 0;
      for (int c = 0; c < W + 4; c++) begin
         if (done === 1'b1) n_done++;
         @(negedge clk);
      end
      check("abort_no_done", n_done, 0);
      prev_d = '0; prev_br = 1'b0;
      run_op(4'b0101, 4'b0011, 4'b0010, 1'b0, 1'b0);

      // start held high: one result every W+2 cycles
      @(negedge clk);
      A = 4'b1000; B = 4'b0110; start = 1'b1;
      @(negedge clk);
      A = 4'b0011; B = 4'b0010;
      n_done = 0; t0 = -1; t1 = -1; r0 = '0; r1 = '0;
      for (int c = 0; c < 2 * W + 6; c++) begin
         if (done === 1'b1) begin
            if (n_done == 0) begin t0 = c; r0 = Diff; end
            else if (n_done == 1) begin t1 = c; r1 = Diff; end
            n_done++;
         end
         @(negedge clk);
      end
      start = 1'b0;
      check("b2b_done_count", n_done, 2);
      check("b2b_spacing", t1 - t0, W + 2);
      check("b2b_first", int'(r0), 4'b0010);
      check("b2b_second", int'(r1), 4'b0001);
      repeat (2 * W + 6) @(negedge clk);
      check("b2b_idle", int'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
